// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for multicycle_alu.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_OR  = 4'b0111;
   localparam logic [3:0] OP_NEG = 4'b1000;
   localparam logic [3:0] OP_NOT = 4'b1010;
   localparam logic [3:0] OP_SRA = 4'b1011;
   localparam logic [3:0] OP_SHL = 4'b1100;
   localparam logic [3:0] OP_SRL = 4'b1101;
   localparam logic [3:0] OP_ROL = 4'b1110;
   localparam logic [3:0] OP_ROR = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: WIDTH iterations over operand magnitudes.
// done_o is combinational and high during the cycle of the final iteration;
// quot_o/rem_o carry the sign-corrected result of that iteration so the parent
// can register it on the same edge.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic signed [WIDTH-1:0] dividend_i,
   input  logic signed [WIDTH-1:0] divisor_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic signed [WIDTH-1:0] quot_o,
   output logic signed [WIDTH-1:0] rem_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvsr_q;
   logic             qneg_q;
   logic             rneg_q;

   logic [WIDTH:0]   rem_sh_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // One restoring step: shift in the next dividend bit, keep the trial subtract if non-negative.
   always_comb begin
      rem_sh_d = {rem_q, quo_q[WIDTH-1]};
      trial_d  = rem_sh_d - {1'b0, dvsr_q};
      if (trial_d[WIDTH]) begin
         rem_d = rem_sh_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_d = trial_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign quot_o = qneg_q ? -quo_d : quo_d;
   assign rem_o  = rneg_q ? -rem_d : rem_d;

   // Iteration control: load magnitudes on start, count WIDTH steps, abort on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i && !busy_q) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= magnitude(dividend_i);
         dvsr_q <= magnitude(divisor_i);
         qneg_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
         rneg_q <= dividend_i[WIDTH-1];
      end else if (busy_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         if (done_o) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle signed ALU: single-cycle logic/arith/shift ops, iterative MUL
// (shift-add) and iterative DIV (seq_divider). Results land in a registered
// {Hi, Lo} Z with a one-cycle done pulse.
// Build option: define ALU_FAST_MUL_EN to compute MUL with a combinational
// signed multiply at single-cycle latency instead of the iterative engine.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic                    start,
   input  logic [3:0]              select,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   output logic                    busy,
   output logic                    done,
   output logic [2*WIDTH-1:0]      Z,
   output logic                    carry,
   output logic                    div_by_zero
);

   import alu_pkg::*;

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH);

   state_e               state_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   z_q;
   logic                 carry_q;
   logic                 dbz_q;

   logic [SH_W-1:0]      amt;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       dif_ext;
   logic [2*WIDTH-1:0]   rol_ext;
   logic [2*WIDTH-1:0]   ror_ext;
   logic [WIDTH-1:0]     lo_res_d;
   logic [2*WIDTH-1:0]   sc_z_d;
   logic                 carry_d;

   logic                 div_start;
   logic                 div_busy;
   logic                 div_done;
   logic signed [WIDTH-1:0] div_quot;
   logic signed [WIDTH-1:0] div_rem;

`ifdef ALU_FAST_MUL_EN
   logic signed [2*WIDTH-1:0] fast_prod;
   assign fast_prod = A * B;
`else
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 mneg_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   prod_step_d;
   logic [2*WIDTH-1:0]   prod_fin_d;

   // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // Shift-add step and the sign-corrected product of the final step.
   always_comb begin
      prod_step_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
      prod_fin_d  = mneg_q ? -prod_step_d : prod_step_d;
   end
`endif

   assign amt = B[SH_W-1:0];

   // Single-cycle result: Lo from the opcode, Hi forced to zero.
   always_comb begin
      sum_ext  = {1'b0, A} + {1'b0, B};
      dif_ext  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
      rol_ext  = {A, A} << amt;
      ror_ext  = {A, A} >> amt;
      lo_res_d = B;
      carry_d  = 1'b0;
      case (select)
         OP_ADD: begin
            lo_res_d = sum_ext[WIDTH-1:0];
            carry_d  = sum_ext[WIDTH];
         end
         OP_SUB: begin
            lo_res_d = dif_ext[WIDTH-1:0];
            carry_d  = dif_ext[WIDTH];
         end
         OP_AND:  lo_res_d = A & B;
         OP_OR:   lo_res_d = A | B;
         OP_NEG:  lo_res_d = -B;
         OP_NOT:  lo_res_d = ~B;
         OP_SRA:  lo_res_d = A >>> amt;
         OP_SHL:  lo_res_d = A << amt;
         OP_SRL:  lo_res_d = A >> amt;
         OP_ROL:  lo_res_d = rol_ext[2*WIDTH-1:WIDTH];
         OP_ROR:  lo_res_d = ror_ext[WIDTH-1:0];
         default: lo_res_d = B;
      endcase
      sc_z_d = {{WIDTH{1'b0}}, lo_res_d};
`ifdef ALU_FAST_MUL_EN
      if (select == OP_MUL) begin
         sc_z_d  = fast_prod;
         carry_d = 1'b0;
      end
`endif
   end

   // The divider is launched on the same edge the controller accepts a non-zero DIV.
   assign div_start = (state_q == ST_IDLE) && start && !clear &&
                      (select == OP_DIV) && (B != '0);

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk_i      (clock),
      .rst_i      (clear),
      .start_i    (div_start),
      .dividend_i (A),
      .divisor_i  (B),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   // Controller FSM with registered busy/done/Z/flags; clear wins over start.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         z_q     <= '0;
         carry_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  busy_q <= 1'b1;
                  if (select == OP_DIV) begin
                     if (B == '0) begin
                        z_q     <= {A, {WIDTH{1'b1}}};
                        carry_q <= 1'b0;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        state_q <= ST_DIV;
                     end
                  end
`ifndef ALU_FAST_MUL_EN
                  else if (select == OP_MUL) begin
                     mcand_q  <= {{WIDTH{1'b0}}, magnitude(A)};
                     mplier_q <= magnitude(B);
                     prod_q   <= '0;
                     mneg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                     cnt_q    <= '0;
                     state_q  <= ST_MUL;
                  end
`endif
                  else begin
                     z_q     <= sc_z_d;
                     carry_q <= carry_d;
                     dbz_q   <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
`ifndef ALU_FAST_MUL_EN
            ST_MUL: begin
               prod_q   <= prod_step_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  z_q     <= prod_fin_d;
                  carry_q <= 1'b0;
                  dbz_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            ST_DIV: begin
               if (div_done) begin
                  z_q     <= {div_rem, div_quot};
                  carry_q <= 1'b0;
                  dbz_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (!div_busy) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign Z           = z_q;
   assign carry       = carry_q;
   assign div_by_zero = dbz_q;

endmodule
